// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite slave backed by a register-array memory
module axi_lite_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [1:0]              s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [1:0]              s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int AL = $clog2(SW);
  localparam int IW = ADDR_WIDTH - AL;
  localparam int MW = $clog2(DEPTH);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t              r_wstate;
  r_state_t              r_rstate;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_awready, r_wready, r_arready;
  logic                  r_aw_held, r_w_held;
  logic [IW-1:0]         r_awidx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_wstrb;
  logic                  r_bvalid, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_aw_fire, w_w_fire, w_aw_have, w_w_have, w_wok, w_rok;
  logic [IW-1:0]         w_widx, w_ridx;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [SW-1:0]         w_wstrb;
  logic                  w_unused;
  // A beat counts as held if it was captured earlier or is being captured this cycle
  assign w_aw_fire = s0_axi_awvalid & r_awready;
  assign w_w_fire  = s0_axi_wvalid & r_wready;
  assign w_aw_have = r_aw_held | w_aw_fire;
  assign w_w_have  = r_w_held | w_w_fire;
  assign w_widx    = r_aw_held ? r_awidx : s0_axi_awaddr[ADDR_WIDTH-1:AL];
  assign w_wdata   = r_w_held ? r_wdata : s0_axi_wdata;
  assign w_wstrb   = r_w_held ? r_wstrb : s0_axi_wstrb;
  assign w_ridx    = s0_axi_araddr[ADDR_WIDTH-1:AL];
  assign w_wok     = 32'(w_widx) < DEPTH;
  assign w_rok     = 32'(w_ridx) < DEPTH;
  assign w_unused  = ^{s0_axi_awaddr[AL-1:0], s0_axi_araddr[AL-1:0]};
  assign s0_axi_awready = r_awready;
  assign s0_axi_wready  = r_wready;
  assign s0_axi_bvalid  = r_bvalid;
  assign s0_axi_bresp   = r_bresp;
  assign s0_axi_arready = r_arready;
  assign s0_axi_rvalid  = r_rvalid;
  assign s0_axi_rdata   = r_rdata;
  assign s0_axi_rresp   = r_rresp;
  // Write FSM: gather AW and W in any order, commit with strobes, then hold B until accepted
  always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
    if (s0_axi_areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awidx   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_wstate == W_IDLE) begin
      if (w_aw_fire) r_awidx <= s0_axi_awaddr[ADDR_WIDTH-1:AL];
      if (w_w_fire) begin
        r_wdata <= s0_axi_wdata;
        r_wstrb <= s0_axi_wstrb;
      end
      if (w_aw_have && w_w_have) begin
        r_wstate  <= W_RESP;
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wok ? 2'b00 : 2'b10;
        if (w_wok)
          for (int b = 0; b < SW; b++)
            if (w_wstrb[b]) r_mem[w_widx[MW-1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
      end else begin
        r_aw_held <= w_aw_have;
        r_w_held  <= w_w_have;
        r_awready <= !w_aw_have;
        r_wready  <= !w_w_have;
      end
    end else if (s0_axi_bready) begin
      r_wstate  <= W_IDLE;
      r_bvalid  <= 1'b0;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
    end
  end
  // Read FSM: sample memory on the AR handshake, hold R until accepted
  always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
    if (s0_axi_areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else if (r_rstate == R_IDLE) begin
      if (s0_axi_arvalid && r_arready) begin
        r_rstate  <= R_DATA;
        r_arready <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= w_rok ? r_mem[w_ridx[MW-1:0]] : '0;
        r_rresp   <= w_rok ? 2'b00 : 2'b10;
      end else begin
        r_arready <= 1'b1;
      end
    end else if (s0_axi_rready) begin
      r_rstate  <= R_IDLE;
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: randomized AXI4-Lite traffic against a word-array model
module tb_axi_lite_mem_slave;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 32;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;
  logic [31:0]   model [DEPTH];
  int            n_chk = 0;
  int            n_pass = 0;
  always #5 clk = ~clk;
  axi_lite_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .s0_axi_aclk(clk), .s0_axi_areset(rst),
    .s0_axi_awaddr(awaddr), .s0_axi_awvalid(awvalid), .s0_axi_awready(awready),
    .s0_axi_wdata(wdata), .s0_axi_wstrb(wstrb), .s0_axi_wvalid(wvalid), .s0_axi_wready(wready),
    .s0_axi_bresp(bresp), .s0_axi_bvalid(bvalid), .s0_axi_bready(bready),
    .s0_axi_araddr(araddr), .s0_axi_arvalid(arvalid), .s0_axi_arready(arready),
    .s0_axi_rdata(rdata), .s0_axi_rresp(rresp), .s0_axi_rvalid(rvalid), .s0_axi_rready(rready)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic bit in_rng(input logic [7:0] a);
    return int'(a) / 4 < DEPTH;
  endfunction
  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    return in_rng(a) ? model[int'(a) / 4] : 32'h0;
  endfunction
  task automatic commit(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[int'(a) / 4][8*b +: 8] = d[8*b +: 8];
  endtask
  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ready"}, {awready, wready, arready}, 3'b000);
    chk({tag, "_valid"}, {bvalid, rvalid}, 2'b00);
    chk({tag, "_resp"}, {bresp, rresp}, 4'b0000);
    chk({tag, "_rdata"}, rdata, 0);
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int da, input int dw);
    bit ad = 0, wd = 0, ha, hw;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(ad && wd) && n < 100) begin
      awvalid = !ad && n >= da;
      wvalid  = !wd && n >= dw;
      ha = awvalid && awready;
      hw = wvalid && wready;
      tick;
      n++;
      ad |= ha;
      wd |= hw;
      if (!(ad && wd)) chk("early_bvalid", bvalid, 0);
    end
    awvalid = 0; wvalid = 0;
    if (!(ad && wd)) chk("wr_timeout", 0, 1);
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, in_rng(a) ? 2'b00 : 2'b10);
    commit(a, d, s);
    bready = 1;
    tick;
    bready = 0;
    chk("bvalid_clr", bvalid, 0);
  endtask
  task automatic rd(input logic [7:0] a);
    int n = 0;
    logic [31:0] e;
    araddr = a; arvalid = 1;
    while (!arready && n < 100) begin
      tick;
      n++;
    end
    if (!arready) chk("rd_timeout", 0, 1);
    e = exp_rd(a);
    tick;
    arvalid = 0;
    chk("rvalid", rvalid, 1);
    chk("rdata", rdata, e);
    chk("rresp", rresp, in_rng(a) ? 2'b00 : 2'b10);
    rready = 1;
    tick;
    rready = 0;
    chk("rvalid_clr", rvalid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] e;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    repeat (2) tick;
    chk_idle_outs("rst_hold");
    rst = 0;
    tick;
    chk("rst_release_ready", {awready, wready, arready}, 3'b111);
    awaddr = 8'h10; awvalid = 1;
    tick;
    awvalid = 0;
    chk("aw_captured", {awready, wready}, 2'b01);
    rst = 1;
    #1;
    chk_idle_outs("rst_mid");
    tick;
    rst = 0;
    tick;
    chk("rst2_ready", {awready, wready, arready}, 3'b111);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1;
    tick;
    wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("dropped_aw_no_b", bvalid, 0);
      tick;
    end
    rst = 1;
    tick;
    rst = 0;
    tick;
    rd(8'h10);
    wr(8'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    rd(8'h10);
    wr(8'h10, 32'h11223344, 4'b0101, 3, 0);
    rd(8'h10);
    chk("strobe_merge", exp_rd(8'h10), 32'hDE22BE44);
    wr(8'h7C, 32'h0BADCAFE, 4'hF, 0, 2);
    rd(8'h7C);
    wr(8'h80, 32'h12345678, 4'hF, 1, 0);
    rd(8'h80);
    wr(8'h0C, 32'h5A5A0000, 4'h0, 0, 0);
    rd(8'h0C);
    awaddr = 8'h04; wdata = 32'h76543210; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 8'h10; arvalid = 1;
    tick;
    awvalid = 0; wvalid = 0; arvalid = 0;
    commit(8'h04, 32'h76543210, 4'hF);
    e = exp_rd(8'h10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {bvalid, rvalid}, 2'b11);
      chk("bp_bresp", bresp, 2'b00);
      chk("bp_rdata", rdata, e);
      chk("bp_ready_low", {awready, wready, arready}, 3'b000);
      tick;
    end
    bready = 1; rready = 1;
    tick;
    bready = 0; rready = 0;
    chk("bp_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
    rd(8'h04);
    awaddr = 8'h20; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 8'h22; arvalid = 1;
    e = exp_rd(8'h20);
    tick;
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("coll_valid", {bvalid, rvalid}, 2'b11);
    chk("coll_old", rdata, e);
    commit(8'h20, 32'hA5A5A5A5, 4'hF);
    bready = 1; rready = 1;
    tick;
    bready = 0; rready = 0;
    rd(8'h20);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1)
        wr(8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        rd(8'($urandom_range(0, 255)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_lite_mem_slave.md
# axi_lite_mem_slave

AXI4-Lite memory-mapped slave that terminates the master-side port of the bus bridge (`m1_axi_*`) and backs it with a register-array memory. It accepts write address and write data independently, applies byte strobes, and returns OKAY or SLVERR responses. Reads and writes proceed concurrently on separate state machines. This is the storage endpoint for all bus-lab traffic.

## Interface
- `DATA_WIDTH`, 32, data bus width; must be 32 or 64.
- `ADDR_WIDTH`, 8, byte address width.
- `DEPTH`, 64, number of DATA_WIDTH-bit words; must satisfy DEPTH*(DATA_WIDTH/8) ≤ 2^ADDR_WIDTH.

Ports:
- `s0_axi_aclk`  in  1  single clock; all logic on rising edge.
- `s0_axi_areset`  in  1  asynchronous, active-high reset.
- `s0_axi_awaddr`  in  ADDR_WIDTH  write byte address.
- `s0_axi_awvalid` in 1 / `s0_axi_awready` out 1  write address handshake.
- `s0_axi_wdata`  in  DATA_WIDTH  write data.
- `s0_axi_wstrb`  in  DATA_WIDTH/8  byte enables; bit i enables wdata[8i+7:8i].
- `s0_axi_wvalid` in 1 / `s0_axi_wready` out 1  write data handshake.
- `s0_axi_bresp`  out  2  00 = OKAY, 10 = SLVERR.
- `s0_axi_bvalid` out 1 / `s0_axi_bready` in 1  write response handshake.
- `s0_axi_araddr`  in  ADDR_WIDTH  read byte address.
- `s0_axi_arvalid` in 1 / `s0_axi_arready` out 1  read address handshake.
- `s0_axi_rdata`  out  DATA_WIDTH  read data.
- `s0_axi_rresp`  out  2  00 = OKAY, 10 = SLVERR.
- `s0_axi_rvalid` out 1 / `s0_axi_rready` in 1  read data handshake.

## Operation
- Word index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored, so unaligned accesses hit the containing word. An index ≥ DEPTH is out of range.
- Write FSM states:
  - **W_IDLE**: awready and wready are high until their beat is captured. AW and W handshakes may occur in the same cycle or in either order, any number of cycles apart.
  - A channel that has captured its beat drops its ready and holds it low until the response completes.
  - When both beats are held (including beats captured in the current cycle), go to **W_RESP**.
  - On that edge, an in-range write is committed per strobe bit with bresp = 00. An out-of-range write is discarded with bresp = 10. bvalid rises.
  - **W_RESP**: bvalid and bresp are held stable until bready. On the bvalid & bready edge, return to W_IDLE with awready = wready = 1.
- Read FSM states:
  - **R_IDLE**: arready = 1. On handshake, rdata is loaded with mem[index] as sampled in the handshake cycle, and rresp = 00. For out-of-range reads, rdata = 0 and rresp = 10. Go to **R_DATA**.
  - **R_DATA**: arready = 0. rvalid, rdata and rresp are held stable until rready. On the rvalid & rready edge, return to R_IDLE.
- Concurrency: the read and write FSMs are independent. If a read samples a word on the same edge a write commits to it, the read returns the pre-write value.
- wstrb = 0 is a legal write: memory is unchanged and the response is OKAY.

## Timing
- Reset (asynchronous assert, synchronous release):
  - All memory words are cleared to 0.
  - awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 00; rdata = 0.
  - Both FSMs go to idle. Readies go to 1 on the first rising edge after reset deasserts.
- Reset asserted mid-transaction aborts it immediately. Any captured but uncommitted beat is dropped and no response is issued.
- All outputs are registered; there is no combinational path from input to output.
- Write latency: from the edge that completes the later of AW/W, bvalid is high in the next cycle. The written data is readable by an AR handshake in that same cycle.
- Read latency: AR handshake in cycle N gives rvalid in cycle N+1.
- Throughput, with ready/bready tied high: one write per 2 cycles and one read per 2 cycles, concurrently.
- The block never deasserts valid or changes data before the handshake completes.

## Test plan
- **Reset values:** assert areset mid-write (AW captured, W pending). All outputs are 0 and no bvalid appears. One cycle after release, awready, wready and arready are all 1.
- **Aligned write then read:** AW 0x10 and W 0xDEADBEEF with wstrb 1111 in the same cycle. Expect bvalid next cycle with bresp 00. Then AR 0x10 gives rdata 0xDEADBEEF, rresp 00, one cycle after the handshake.
- **Byte strobes and skewed channels:** W 0x11223344 with wstrb 0101 presented 3 cycles before AW 0x10, with word 0x10 holding 0xDEADBEEF. Expect no bvalid until one cycle after AW. A read then returns 0xDE22BE44.
- **Out of range:** with DEPTH 64 and DATA_WIDTH 32, AW 0xFC is in range (index 63) and gets bresp 00. With DEPTH 32, AW 0x80 gets bresp 10 and memory is unchanged. AR 0x80 returns rdata 0 with rresp 10.
- **Backpressure:** hold bready and rready low for 5 cycles. bvalid, bresp, rvalid and rdata stay stable, and awready, wready and arready stay low until release.
- **Same-edge collision:** word 0x20 holds 0x0. The write to 0x20 with 0xA5A5A5A5 commits on the same edge as the AR handshake for 0x20. The read returns 0x0, and a subsequent read returns 0xA5A5A5A5.
